// File: rtl/serial_adder_ctrl_pkg.sv
// serial_add_pkg: shared FSM state encoding and default width for the serial adder
package serial_add_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: start/busy/done command bus for the serial adder
// master drives start, a, b, cin; slave returns busy, done, sum, cout
interface serial_adder_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_ctrl_full_adder_bit.sv
// full_adder_bit: one-bit full adder built from two half adders and an OR
// half_adder ports: i_a, i_b -> o_s, o_c; full_adder_bit ports: i_a, i_b, i_cin -> o_s, o_co
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module full_adder_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_co
);
    logic w_s1, w_c1, w_c2;
    half_adder u_ha0 (.i_a(i_a), .i_b(i_b), .o_s(w_s1), .o_c(w_c1));
    half_adder u_ha1 (.i_a(w_s1), .i_b(i_cin), .o_s(o_s), .o_c(w_c2));
    assign o_co = w_c1 | w_c2;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: WIDTH-bit add done LSB-first through one full adder, one bit per clock
// ports: clk, rst_n (async active-low), bus (slave: start/a/b/cin in, busy/done/sum/cout out)
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input logic                clk,
    input logic                rst_n,
    serial_adder_ctrl_if.slave bus
);
    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_res, r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_c, r_busy, r_done, r_cout;
    logic             w_s, w_co;
    logic [WIDTH-1:0] w_res;

    full_adder_bit u_fa (.i_a(r_a[0]), .i_b(r_b[0]), .i_cin(r_c), .o_s(w_s), .o_co(w_co));

    // result fills from the top so the LSB lands at bit 0 after WIDTH shifts
    assign w_res = {w_s, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_c     <= bus.cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_c   <= w_co;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_sum   <= w_res;
                        r_cout  <= w_co;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of the serial adder at WIDTH=8 and exhaustive WIDTH=2
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(2)) bus2 ();

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder_ctrl #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic ec);
        logic [7:0] prev;
        int         nb;
        logic       ok;
        prev = bus8.sum;
        ok = 1'b1;
        nb = 0;
        bus8.a = ta;
        bus8.b = tb;
        bus8.cin = tc;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.a = ~ta;
        bus8.b = ~tb;
        bus8.cin = ~tc;
        while (bus8.busy && nb < 20) begin
            if (bus8.done || bus8.sum !== prev) ok = 1'b0;
            nb++;
            tick();
        end
        chk("busy_len", nb, 8);
        chk("run_quiet", ok, 1);
        chk("done_pulse", bus8.done, 1);
        chk("sum", bus8.sum, es);
        chk("cout", bus8.cout, ec);
        tick();
        chk("done_drop", bus8.done, 0);
    endtask

    initial begin
        logic [7:0] ga [0:29];
        logic [7:0] gb [0:29];
        logic       gc [0:29];
        logic       quiet;
        int         nd;

        bus8.start = 1'b1;
        bus8.a = 8'h0F;
        bus8.b = 8'h01;
        bus8.cin = 1'b1;
        bus2.start = 1'b0;
        bus2.a = '0;
        bus2.b = '0;
        bus2.cin = 1'b0;
        tick();
        tick();
        chk("rst_busy", bus8.busy, 0);
        chk("rst_done", bus8.done, 0);
        chk("rst_sum", bus8.sum, 0);
        chk("rst_cout", bus8.cout, 0);
        bus8.start = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_busy", bus8.busy, 0);
        chk("post_rst_done", bus8.done, 0);
        chk("post_rst_sum", bus8.sum, 0);

        add8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        add8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        add8(8'hA5, 8'h3C, 1'b1, 8'hE2, 1'b0);

        // start held high with fresh operands every cycle; accepts land every 10 edges
        for (int i = 0; i < 30; i++) begin
            ga[i] = 8'(i * 37 + 5);
            gb[i] = 8'(i * 91 + 200);
            gc[i] = i[0];
        end
        for (int i = 0; i < 30; i++) begin
            bus8.start = 1'b1;
            bus8.a = ga[i];
            bus8.b = gb[i];
            bus8.cin = gc[i];
            tick();
            chk("hs_busy", bus8.busy, 32'((i % 10) <= 7));
            chk("hs_done", bus8.done, 32'((i % 10) == 8));
            if (i % 10 == 8)
                chk("hs_result", {bus8.cout, bus8.sum},
                    9'({1'b0, ga[i-8]} + {1'b0, gb[i-8]} + 9'(gc[i-8])));
        end
        bus8.start = 1'b0;
        tick();

        bus8.a = 8'hAA;
        bus8.b = 8'h55;
        bus8.cin = 1'b0;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_busy_before", bus8.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_busy", bus8.busy, 0);
        chk("mid_done", bus8.done, 0);
        chk("mid_sum", bus8.sum, 0);
        chk("mid_cout", bus8.cout, 0);
        #2 rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus8.done || bus8.busy) quiet = 1'b0;
        end
        chk("abort_quiet", quiet, 1);

        // WIDTH=2: each vector held 4 edges so every accept sees a new (a,b,cin)
        nd = 0;
        for (int i = 0; i < 128; i++) begin
            logic [4:0] v;
            logic [4:0] w;
            v = 5'(i / 4);
            bus2.start = 1'b1;
            bus2.a = v[1:0];
            bus2.b = v[3:2];
            bus2.cin = v[4];
            tick();
            if (bus2.done) nd++;
            chk("w2_done", bus2.done, 32'((i % 4) == 2));
            if (i % 4 == 2) begin
                w = 5'((i - 2) / 4);
                chk("w2_result", {bus2.cout, bus2.sum},
                    3'({1'b0, w[1:0]} + {1'b0, w[3:2]} + 3'(w[4])));
            end
        end
        bus2.start = 1'b0;
        tick();
        tick();
        chk("w2_pulses", nd, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
